// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, ALU operations, branch
// conditions, condition-code record and the condition evaluator.
package y86_pkg;

   localparam logic [3:0] RNONE = 4'hF;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_XOR = 2'd3
   } alu_op_e;

   typedef enum logic [3:0] {
      C_ALWAYS = 4'h0,
      C_LE     = 4'h1,
      C_L      = 4'h2,
      C_E      = 4'h3,
      C_NE     = 4'h4,
      C_GE     = 4'h5,
      C_G      = 4'h6
   } cond_e;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   // Branch / conditional-move predicate; undefined condition codes never take.
   function automatic logic cond_eval(input cc_t cc, input logic [3:0] ifun);
      logic lt;
      logic res;
      lt  = cc.sf ^ cc.of;
      res = 1'b0;
      case (ifun)
         C_ALWAYS: res = 1'b1;
         C_LE:     res = lt | cc.zf;
         C_L:      res = lt;
         C_E:      res = cc.zf;
         C_NE:     res = ~cc.zf;
         C_GE:     res = ~lt;
         C_G:      res = ~lt & ~cc.zf;
         default:  res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode->execute request and execute->memory response bundle.
interface execute_stage_if #(parameter int W = 64);

   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_icode;
   logic [3:0]   in_ifun;
   logic [W-1:0] in_valA;
   logic [W-1:0] in_valB;
   logic [W-1:0] in_valC;
   logic [3:0]   in_dstE;
   logic [3:0]   in_dstM;

   logic         out_valid;
   logic         out_ready;
   logic [3:0]   out_icode;
   logic         out_cnd;
   logic [W-1:0] out_valE;
   logic [W-1:0] out_valA;
   logic [3:0]   out_dstE;
   logic [3:0]   out_dstM;

   modport master (
      output in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, in_dstE, in_dstM,
      output out_ready,
      input  in_ready,
      input  out_valid, out_icode, out_cnd, out_valE, out_valA, out_dstE, out_dstM
   );

   modport slave (
      input  in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, in_dstE, in_dstM,
      input  out_ready,
      output in_ready,
      output out_valid, out_icode, out_cnd, out_valE, out_valA, out_dstE, out_dstM
   );

endinterface

// File: rtl/execute_stage_alu64.sv
// Combinational Y86-64 ALU: add, subtract, and, xor with signed-overflow flag.
module alu64
   import y86_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  alu_op_e      op,
   output logic [W-1:0] result,
   output logic         of
);

   logic         sub;
   logic [W-1:0] a_eff;
   logic [W-2:0] low;
   logic         c_msb_in;
   logic [1:0]   msb_sum;

   // Subtraction is b + ~a + 1 so one adder serves both; the MSB is added
   // separately to expose the carry into and out of the sign bit.
   assign sub   = (op == ALU_SUB);
   assign a_eff = sub ? ~a : a;
   assign {c_msb_in, low} = {1'b0, b[W-2:0]} + {1'b0, a_eff[W-2:0]} + {{(W-1){1'b0}}, sub};
   assign msb_sum = {1'b0, b[W-1]} + {1'b0, a_eff[W-1]} + {1'b0, c_msb_in};

   // Result and overflow selection by operation.
   always_comb begin
      result = '0;
      of     = 1'b0;
      case (op)
         ALU_ADD, ALU_SUB: begin
            result = {msb_sum[0], low};
            of     = msb_sum[1] ^ c_msb_in;
         end
         ALU_AND: result = b & a;
         ALU_XOR: result = b ^ a;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, condition
// evaluation and a one-entry E->M pipeline register.
module execute_stage #(
   parameter int         W     = 64,
   parameter logic [3:0] RNONE = 4'hF
) (
   input  logic            clk,
   input  logic            rst,
   execute_stage_if.slave  bus,
   output logic            cc_zf,
   output logic            cc_sf,
   output logic            cc_of
);

   import y86_pkg::*;

   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [W-1:0] alu_res;
   logic         alu_of;
   alu_op_e      alu_op;
   logic         op_ok;
   logic [W-1:0] val_e;
   logic         cnd;
   logic [3:0]   dst_e;
   logic         accept;
   logic         cc_load;
   cc_t          cc;
   cc_t          cc_next;

   assign bus.in_ready = ~bus.out_valid | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;

   // ALU operand selection by instruction class.
   always_comb begin
      alu_a = '0;
      alu_b = '0;
      case (bus.in_icode)
         I_RRMOVQ, I_OPQ:            alu_a = bus.in_valA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = bus.in_valC;
         I_CALL, I_PUSHQ:            alu_a = {{(W-4){1'b1}}, 4'h8};
         I_RET, I_POPQ:              alu_a = W'(8);
         default:                    alu_a = '0;
      endcase
      case (bus.in_icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = bus.in_valB;
         default:                                                    alu_b = '0;
      endcase
   end

   alu64 #(.W(W)) u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .op     (alu_op),
      .result (alu_res),
      .of     (alu_of)
   );

   // ALU op decode, result gating, new flags, condition and destination.
   always_comb begin
      op_ok  = (bus.in_icode == I_OPQ) && (bus.in_ifun <= 4'd3);
      alu_op = op_ok ? alu_op_e'(bus.in_ifun[1:0]) : ALU_ADD;
      val_e  = ((bus.in_icode == I_OPQ) && !op_ok) ? '0 : alu_res;

      cc_next.zf = (alu_res == '0);
      cc_next.sf = alu_res[W-1];
      cc_next.of = alu_of;
      cc_load    = accept & op_ok;

      cnd = 1'b1;
      if ((bus.in_icode == I_RRMOVQ) || (bus.in_icode == I_JXX))
         cnd = cond_eval(cc, bus.in_ifun);

      dst_e = ((bus.in_icode == I_RRMOVQ) && !cnd) ? RNONE : bus.in_dstE;
   end

   // E->M register: load on accept, otherwise drain when memory consumes.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_icode <= '0;
         bus.out_cnd   <= 1'b0;
         bus.out_valE  <= '0;
         bus.out_valA  <= '0;
         bus.out_dstE  <= RNONE;
         bus.out_dstM  <= RNONE;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.out_icode <= bus.in_icode;
         bus.out_cnd   <= cnd;
         bus.out_valE  <= val_e;
         bus.out_valA  <= bus.in_valA;
         bus.out_dstE  <= dst_e;
         bus.out_dstM  <= bus.in_dstM;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

   // Condition-code register, written only by accepted valid OPq.
   always_ff @(posedge clk) begin
      if (rst) begin
         cc <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
      end else if (cc_load) begin
         cc <= cc_next;
      end
   end

   assign cc_zf = cc.zf;
   assign cc_sf = cc.sf;
   assign cc_of = cc.of;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- 64-bit Y86-64 execute stage, directly downstream of decode and upstream of memory.
- Selects ALU operands and performs add/sub/and/xor using the team's ADDER64/SUBTRACTOR64/AND64/XOR64 semantics.
- Maintains the ZF/SF/OF condition-code register and evaluates branch/cmov conditions.
- Registers results into a one-entry E->M pipeline register with a valid/ready handshake.

Parameters:
- W, 64, datapath width.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_icode  in  4  instruction code.
- in_ifun  in  4  function code: ALU op or condition.
- in_valA  in  W  operand A from decode.
- in_valB  in  W  operand B from decode.
- in_valC  in  W  immediate or displacement.
- in_dstE  in  4  E-destination register ID.
- in_dstM  in  4  M-destination register ID.
- out_valid  out  1  E->M register holds a valid instruction.
- out_ready  in  1  memory stage consumes this cycle.
- out_icode  out  4  registered icode.
- out_cnd  out  1  condition result for jXX/cmovXX; 1 for all other icodes.
- out_valE  out  W  ALU result.
- out_valA  out  W  pass-through of valA.
- out_dstE  out  4  E-destination; forced to RNONE for a not-taken cmov.
- out_dstM  out  4  pass-through of dstM.
- cc_zf  out  1  current zero flag.
- cc_sf  out  1  current sign flag.
- cc_of  out  1  current overflow flag.

Behaviour:
- Reset (rst=1 at edge):
  - out_valid=0; out_icode=0, out_cnd=0, out_valE=0, out_valA=0.
  - out_dstE=out_dstM=RNONE.
  - cc_zf=1, cc_sf=0, cc_of=0.
  - Any held entry is dropped; no CC update in that cycle.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept = in_valid & in_ready. Latency 1: an instruction accepted at edge N appears with out_valid=1 after edge N.
  - If out_valid & !out_ready, every out_* holds and in_ready=0.
  - If out_ready=1 and no accept, out_valid clears next edge.
  - Simultaneous consume and accept replaces the entry; full throughput, no bubble.
- aluA select:
  - valA for rrmovq(2) and OPq(6).
  - valC for irmovq(3), rmmovq(4), mrmovq(5).
  - -8 for call(8) and pushq(A).
  - +8 for ret(9) and popq(B).
  - 0 otherwise.
- aluB select:
  - valB for 4,5,6,8,9,A,B.
  - 0 for 2 and 3.
  - 0 otherwise.
- ALU op: ifun for icode 6; add for every other icode.
  - 0 add: aluB + aluA.
  - 1 sub: aluB - aluA.
  - 2 and.
  - 3 xor.
  - ifun>3 on OPq: result 0, CC unchanged.
- Arithmetic is two's complement mod 2^64 with no saturation.
- OF = carry into bit 63 XOR carry out of bit 63 for add/sub; OF=0 for and/xor.
- CC update:
  - Only on accept of icode 6 with ifun<=3.
  - ZF = result==0; SF = result[63]; OF as above.
  - New CC is visible from the next cycle, so an OPq then jXX accepted back-to-back sees the updated flags.
- Condition eval: uses CC current at accept.
  - ifun 0 always, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne !ZF, 5 ge !(SF^OF), 6 g !(SF^OF)&!ZF.
  - ifun>6 evaluates to 0.
  - Applies to icode 2 (cmov) and 7 (jXX).
- Not-taken cmov: icode 2 with cnd=0 registers out_dstE=RNONE.
- Unknown icode: passed through with valE=aluB+aluA (both 0) and CC untouched.

Decomposition:
- Shared package y86_pkg:
  - icode constants (HALT..POPQ).
  - ALU op enum (ADD/SUB/AND/XOR).
  - Condition enum (ALWAYS..G).
  - RNONE.
  - CC struct {zf,sf,of}.
- Sub-module alu64: combinational, ops add/sub/and/xor, outputs result and OF. Built from the team's 64-bit adder/subtractor/and/xor blocks.
- cond_eval: a function in y86_pkg.

Test Plan:
- Reset then idle -> out_valid=0, out_dstE=F, CC=(1,0,0), in_ready=1.
- OPq add (icode 6, ifun 0), valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> next cycle valE=0x8000_0000_0000_0000; CC becomes (0,1,1).
- OPq sub, valA=5, valB=5, followed immediately by jXX e (icode 7, ifun 3) -> sub valE=0 with ZF=1; jXX out_cnd=1 on the next cycle.
- cmovl (icode 2, ifun 2) with CC=(0,0,0), valA=0x1234, dstE=3 -> out_cnd=0, out_dstE=F, valE=0x1234.
- pushq, valB=0x100 -> valE=0xF8 and CC unchanged. Then popq with out_ready=0 for 3 cycles -> outputs hold, in_ready=0. After release, popq valE=0x108.
- Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and CC=(1,0,0).
